// File: rtl/hdmi_rx_lock_ctrl.sv
// Video-timing lock controller for the HDMI RX->TX passthrough path.
// Measures line/frame geometry from the DE/HS/VS stream, declares lock after
// STABLE_FRAMES identical frames, and requests a receiver resync on loss.
module hdmi_rx_lock_ctrl #(
  parameter int CNT_W         = 12,
  parameter int STABLE_FRAMES = 3,
  parameter int TIMEOUT_CYC   = 2_000_000,
  parameter int TO_W          = 22,
  parameter int RST_CYC       = 16
) (
  input  logic             hdmi_rx_clk,
  input  logic             rst,
  input  logic             hdmi_rx_de,
  input  logic             hdmi_rx_vs,
  input  logic             hdmi_rx_hs,
  output logic             video_locked,
  output logic             tx_en,
  output logic             lock_lost,
  output logic             rx_rst,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active
);

  localparam int MW = $clog2(STABLE_FRAMES) + 1;
  localparam int RW = $clog2(RST_CYC) + 1;

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED, S_LOST} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] ht;
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] vt;
    logic [CNT_W-1:0] va;
  } timing_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       rst_pipe_q;
  logic             rst_int;
  logic             de_r_q, hs_r_q, vs_r_q, hs_d1_q, vs_d1_q;
  logic             hs_edge, vs_edge;
  logic [CNT_W-1:0] pix_cnt_q, de_cnt_q, line_cnt_q, act_cnt_q, h_last_q, ha_last_q;
  logic [CNT_W-1:0] de_tot;
  logic             line_has_de;
  logic [TO_W-1:0]  to_cnt_q;
  logic             timeout;
  timing_t          cand, prev_q, prev_d, out_q, out_d;
  logic             cand_valid, frame_ok;
  logic [MW-1:0]    match_q, match_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  state_e           state_q, state_d;

  // Reset pipeline: asserts with rst immediately, releases two clock edges later.
  always_ff @(posedge hdmi_rx_clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end
  assign rst_int = rst_pipe_q[1];

  // Register the video controls once and keep a delayed copy for edge detection.
  always_ff @(posedge hdmi_rx_clk or posedge rst_int) begin
    if (rst_int) begin
      {de_r_q, hs_r_q, vs_r_q, hs_d1_q, vs_d1_q} <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      de_r_q  <= hdmi_rx_de;
      hs_r_q  <= hdmi_rx_hs;
      vs_r_q  <= hdmi_rx_vs;
      hs_d1_q <= hs_r_q;
      vs_d1_q <= vs_r_q;
    end
  end

  assign hs_edge     = hs_r_q & ~hs_d1_q;
  assign vs_edge     = vs_r_q & ~vs_d1_q;
  assign de_tot      = de_r_q ? sat_inc(de_cnt_q) : de_cnt_q;
  assign line_has_de = (de_tot != '0);
  assign timeout     = (to_cnt_q == TO_W'(TIMEOUT_CYC));

  // A line closing on the same cycle as VS belongs to the frame that VS closes.
  assign cand.ht = hs_edge ? pix_cnt_q : h_last_q;
  assign cand.ha = (hs_edge && line_has_de) ? de_tot : ha_last_q;
  assign cand.vt = hs_edge ? sat_inc(line_cnt_q) : line_cnt_q;
  assign cand.va = (hs_edge && line_has_de) ? sat_inc(act_cnt_q) : act_cnt_q;

  assign cand_valid = (cand.ht != '0) && !(&cand.ht) && (cand.ha != '0) && !(&cand.ha) &&
                      (cand.vt != '0) && !(&cand.vt) && (cand.va != '0) && !(&cand.va);
  assign frame_ok   = cand_valid && (cand == prev_q);

  // Line/frame measurement counters and the VS watchdog.
  always_ff @(posedge hdmi_rx_clk or posedge rst_int) begin
    if (rst_int) begin
      pix_cnt_q  <= '0;
      de_cnt_q   <= '0;
      line_cnt_q <= '0;
      act_cnt_q  <= '0;
      h_last_q   <= '0;
      ha_last_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      pix_cnt_q <= hs_edge ? CNT_W'(1) : sat_inc(pix_cnt_q);
      de_cnt_q  <= hs_edge ? '0 : de_tot;
      if (vs_edge) begin
        line_cnt_q <= '0;
        act_cnt_q  <= '0;
        h_last_q   <= '0;
        ha_last_q  <= '0;
      end else if (hs_edge) begin
        line_cnt_q <= sat_inc(line_cnt_q);
        h_last_q   <= pix_cnt_q;
        if (line_has_de) begin
          act_cnt_q <= sat_inc(act_cnt_q);
          ha_last_q <= de_tot;
        end
      end
      if (vs_edge)      to_cnt_q <= TO_W'(1);
      else if (!timeout) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // FSM and frame-compare state register.
  always_ff @(posedge hdmi_rx_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= S_SEARCH;
      match_q   <= '0;
      rst_cnt_q <= '0;
      prev_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      rst_cnt_q <= rst_cnt_d;
      prev_q    <= prev_d;
      out_q     <= out_d;
    end
  end

  // Next-state, frame comparison and status outputs.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    match_d      = match_q;
    rst_cnt_d    = rst_cnt_q;
    prev_d       = prev_q;
    out_d        = out_q;
    video_locked = 1'b0;
    lock_lost    = 1'b0;
    rx_rst       = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        if (vs_edge) begin
          state_d = S_MEASURE;
          match_d = '0;
          prev_d  = '0;
        end
      end
      S_MEASURE: begin
        if (timeout) begin
          state_d = S_SEARCH;
          match_d = '0;
        end else if (vs_edge) begin
          prev_d = cand;
          if (!frame_ok) begin
            match_d = '0;
          end else if (match_q == MW'(STABLE_FRAMES - 2)) begin
            match_d = MW'(STABLE_FRAMES - 1);
            state_d = S_LOCKED;
            out_d   = cand;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
      end
      S_LOCKED: begin
        video_locked = 1'b1;
        if (timeout || (vs_edge && !frame_ok)) begin
          state_d   = S_LOST;
          rst_cnt_d = '0;
          out_d     = '0;
        end else if (vs_edge) begin
          prev_d = cand;
        end
      end
      S_LOST: begin
        rx_rst    = 1'b1;
        lock_lost = (rst_cnt_q == '0);
        if (rst_cnt_q == RW'(RST_CYC - 1)) begin
          state_d   = S_SEARCH;
          match_d   = '0;
          rst_cnt_d = '0;
          out_d     = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  assign tx_en    = video_locked;
  assign h_total  = out_q.ht;
  assign h_active = out_q.ha;
  assign v_total  = out_q.vt;
  assign v_active = out_q.va;

endmodule

// File: tb/tb_hdmi_rx_lock_ctrl.sv
// Self-checking bench for hdmi_rx_lock_ctrl: frame table with scoreboard,
// plus hand sequences for loss, timeout and counter saturation.
module tb_hdmi_rx_lock_ctrl;

  localparam int H = 20, HA = 12, V = 10, VA = 6;

  logic clk = 1'b0, rst = 1'b1, de = 1'b0, hs = 1'b0, vs = 1'b0;

  logic        m_locked, m_tx_en, m_lost, m_rxrst;
  logic [11:0] m_ht, m_ha, m_vt, m_va;
  logic        t_locked, t_tx_en, t_lost, t_rxrst;
  logic [11:0] t_ht, t_ha, t_vt, t_va;
  logic        c_locked, c_tx_en, c_lost, c_rxrst;
  logic [7:0]  c_ht, c_ha, c_vt, c_va;

  hdmi_rx_lock_ctrl dut (
    .hdmi_rx_clk(clk), .rst(rst), .hdmi_rx_de(de), .hdmi_rx_vs(vs), .hdmi_rx_hs(hs),
    .video_locked(m_locked), .tx_en(m_tx_en), .lock_lost(m_lost), .rx_rst(m_rxrst),
    .h_total(m_ht), .h_active(m_ha), .v_total(m_vt), .v_active(m_va));

  hdmi_rx_lock_ctrl #(.TIMEOUT_CYC(1000)) dut_tmo (
    .hdmi_rx_clk(clk), .rst(rst), .hdmi_rx_de(de), .hdmi_rx_vs(vs), .hdmi_rx_hs(hs),
    .video_locked(t_locked), .tx_en(t_tx_en), .lock_lost(t_lost), .rx_rst(t_rxrst),
    .h_total(t_ht), .h_active(t_ha), .v_total(t_vt), .v_active(t_va));

  hdmi_rx_lock_ctrl #(.CNT_W(8)) dut_c8 (
    .hdmi_rx_clk(clk), .rst(rst), .hdmi_rx_de(de), .hdmi_rx_vs(vs), .hdmi_rx_hs(hs),
    .video_locked(c_locked), .tx_en(c_tx_en), .lock_lost(c_lost), .rx_rst(c_rxrst),
    .h_total(c_ht), .h_active(c_ha), .v_total(c_vt), .v_active(c_va));

  always #5 clk = ~clk;

  typedef struct {
    int ht, ha, vt, va;
    bit rm;
    bit lk;
    int eht, eha, evt, eva;
  } vec_t;

  typedef struct {
    bit lk;
    int ht, ha, vt, va;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0, n_fail = 0;
  int ll_cnt = 0, rr_cnt = 0, c8_lock_cnt = 0, c8_rst_cnt = 0;
  bit t5_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int ht, ha, vt, va, input bit rm, lk, input int eh, ea, ev, ew);
    vec_t v;
    v.ht = ht; v.ha = ha; v.vt = vt; v.va = va; v.rm = rm; v.lk = lk;
    v.eht = eh; v.eha = ea; v.evt = ev; v.eva = ew;
    vecs.push_back(v);
  endtask

  // Main-DUT status monitors and the CNT_W=8 observation window.
  always @(negedge clk) begin
    if (m_lost)  ll_cnt++;
    if (m_rxrst) rr_cnt++;
    if (t5_on && c_locked) c8_lock_cnt++;
    if (t5_on && c_rxrst)  c8_rst_cnt++;
  end

  // One frame: VS and HS rise together at pixel 0 of line 0, DE on lines 1..va.
  task automatic send_frame(input int idx, input vec_t v);
    exp_t e;
    for (int l = 0; l < v.vt; l++) begin
      for (int p = 0; p < v.ht; p++) begin
        @(negedge clk);
        hs = (p < 2);
        vs = (l == 0) && (p < 2);
        de = (l >= 1) && (l <= v.va) && (p >= 4) && (p < 4 + v.ha);
        if (l == 0 && p == 0) begin
          e.lk = v.lk; e.ht = v.eht; e.ha = v.eha; e.vt = v.evt; e.va = v.eva;
          sb.push_back(e);
        end
        if (l == 0 && p == 2) begin
          e = sb.pop_front();
          check($sformatf("row%0d video_locked", idx), m_locked, e.lk);
          check($sformatf("row%0d tx_en", idx), m_tx_en, e.lk);
          check($sformatf("row%0d h_total", idx), m_ht, e.ht);
          check($sformatf("row%0d h_active", idx), m_ha, e.ha);
          check($sformatf("row%0d v_total", idx), m_vt, e.vt);
          check($sformatf("row%0d v_active", idx), m_va, e.va);
        end
        if (v.rm && l == 3 && p == 0) begin
          rst = 1'b1;
          #1;
          check($sformatf("row%0d rst video_locked", idx), m_locked, 0);
          check($sformatf("row%0d rst tx_en", idx), m_tx_en, 0);
          check($sformatf("row%0d rst h_total", idx), m_ht, 0);
          check($sformatf("row%0d rst v_active", idx), m_va, 0);
        end
        if (v.rm && l == 3 && p == 3) rst = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, got_rx;
    // Frame table: stimulus geometry, reset-mid-frame flag, expected state after its VS.
    for (int i = 0; i < 3; i++) add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);      // rows 0-2
    for (int i = 0; i < 2; i++) add(H, HA, V, VA, 0, 1, H, HA, V, VA);    // rows 3-4
    add(H + 1, HA, V, VA, 0, 1, H, HA, V, VA);                           // row 5 bad line length
    for (int i = 0; i < 4; i++) add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);      // rows 6-9
    add(H, HA, V, VA, 1, 1, H, HA, V, VA);                               // row 10 reset while locked
    add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);                                 // row 11
    add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);                                 // row 12
    add(H, HA, V, VA, 1, 0, 0, 0, 0, 0);                                 // row 13 reset, match_cnt=1
    for (int i = 0; i < 3; i++) add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);      // rows 14-16
    add(H, HA, V, VA, 1, 1, H, HA, V, VA);                               // row 17 reset
    for (int i = 0; i < 6; i++) add(H, HA, V + (i % 2), VA, 0, 0, 0, 0, 0, 0); // rows 18-23
    for (int i = 0; i < 3; i++) add(H, HA, V, VA, 0, 0, 0, 0, 0, 0);      // rows 24-26
    add(H, HA, V, VA, 0, 1, H, HA, V, VA);                               // row 27
    for (int i = 0; i < 3; i++) add(300, 12, 4, 2, 0, 0, 0, 0, 0, 0);     // rows 28-30
    for (int i = 0; i < 2; i++) add(300, 12, 4, 2, 0, 1, 300, 12, 4, 2);  // rows 31-32

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset video_locked", m_locked, 0);
    check("reset tx_en", m_tx_en, 0);
    check("reset lock_lost", m_lost, 0);
    check("reset rx_rst", m_rxrst, 0);
    check("reset h_total", m_ht, 0);
    check("reset h_active", m_ha, 0);
    check("reset v_total", m_vt, 0);
    check("reset v_active", m_va, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 28) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        t5_on = 1'b1;
      end
      send_frame(i, vecs[i]);
      if (i == 4) check("no lock_lost while locking", ll_cnt, 0);
      if (i == 6) begin
        check("lock_lost pulse cycles", ll_cnt, 1);
        check("rx_rst pulse cycles", rr_cnt, 16);
      end
      if (i == 27) begin
        // Hold VS low: the short-timeout instance must drop 1000 cycles later than a VS mismatch would.
        check("tmo locked before timeout", t_locked, 1);
        check("tmo tx_en before timeout", t_tx_en, 1);
        check("tmo h_total", t_ht, H);
        check("tmo h_active", t_ha, HA);
        check("tmo v_total", t_vt, V);
        check("tmo v_active", t_va, VA);
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        got = -1;
        got_rx = 0;
        for (int k = vecs[i].ht * vecs[i].vt; k <= 1200; k++) begin
          @(negedge clk);
          if (t_lost) begin
            got = k;
            got_rx = t_rxrst;
            break;
          end
        end
        check("tmo lock_lost cycle after VS", got, 1002);
        check("tmo rx_rst with lock_lost", got_rx, 1);
        check("main stays locked without VS", m_locked, 1);
      end
    end
    t5_on = 1'b0;

    check("cnt8 never locked", c8_lock_cnt, 0);
    check("cnt8 no rx_rst", c8_rst_cnt, 0);
    check("cnt8 tx_en", c_tx_en, 0);
    check("cnt8 lock_lost", c_lost, 0);
    check("cnt8 h_total", c_ht, 0);
    check("cnt8 h_active", c_ha, 0);
    check("cnt8 v_total", c_vt, 0);
    check("cnt8 v_active", c_va, 0);
    check("total lock_lost cycles", ll_cnt, 1);
    check("total rx_rst cycles", rr_cnt, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
